rv32_mc_control: RTL and testbench
==================================

Name: rv32_mc_control

Overview:
Multi-cycle main controller for the RV32I core. It is the sequential successor to the single-cycle opcode decoder. A Moore FSM sequences fetch, decode, execute, memory and writeback over several cycles, and waits on a memory ready handshake. It sits between the instruction register's opcode field and the shared-ALU/single-memory datapath, and drives every mux select and write strobe.

Parameters:
EN_JALR, 1, 1 = JALR (1100111) is decoded; 0 = JALR is treated as illegal.
EN_UPPER, 1, 1 = LUI (0110111) and AUIPC (0010111) are decoded; 0 = both are illegal.
MEM_HS, 1, 1 = memory states wait for mem_ready; 0 = mem_ready is ignored and taken as 1.

Ports:
clk  in  1  core clock; all state changes on the rising edge.
rst_n  in  1  asynchronous active-low reset.
opcode  in  7  IR[6:0]; must be stable from DECODE until the instruction returns to FETCH.
mem_ready  in  1  memory has accepted the write or returned read data this cycle.
pc_write  out  1  unconditional PC load.
branch  out  1  conditional PC load; the datapath qualifies it with the ALU zero/compare result.
adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
mem_read  out  1  memory read request.
mem_write  out  1  memory write request.
ir_write  out  1  IR and OldPC load.
result_src  out  2  result mux: 00 = ALUOut, 01 = memory data, 10 = ALU direct.
alu_src_a  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
alu_src_b  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4.
alu_op  out  2  ALU op class: 00 = add, 01 = branch compare, 10 = funct-decoded.
reg_write  out  1  register file write.
illegal  out  1  high in TRAP.

Behaviour:
- Reset: while rst_n=0, state=FETCH asynchronously and every strobe (pc_write, branch, mem_read, mem_write, ir_write, reg_write, illegal) is forced to 0. Selects take their FETCH values. Reset mid-instruction abandons the instruction without any write. First fetch starts the cycle after rst_n rises.
- Outputs are a decode of the state register; only the handshake-qualified strobes also depend on mem_ready.
- Any output not listed in a state below is 0.
- FETCH: adr_src=0, mem_read=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. ir_write=pc_write=mem_ready. Goes to DECODE when mem_ready, else holds.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00, so ALUOut=OldPC+imm. Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1101111 -> JAL
  - 1100111 -> JALR_ADR
  - 1100011 -> BRANCH
  - 0110111 or 0010111 -> UPPER
  - anything else, or a class disabled by parameter -> TRAP
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Goes to MEMREAD if opcode[5]=0, else MEMWRITE.
- MEMREAD: adr_src=1, mem_read=1. Holds until mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: adr_src=1, mem_write=1. Holds until mem_ready, then FETCH.
- EXEC_R: alu_src_a=10, alu_src_b=00, alu_op=10, then ALUWB.
- EXEC_I: same as EXEC_R but alu_src_b=01, then ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- JALR_ADR: alu_src_a=10, alu_src_b=01, alu_op=00, then JAL. The datapath clears bit 0 of the target.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1. PC takes the target from ALUOut while the ALU forms the link value; then ALUWB.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1, then FETCH.
- UPPER: alu_src_a=11 for LUI (opcode[5]=1) or 01 for AUIPC; alu_src_b=01, alu_op=00; then ALUWB.
- TRAP: illegal=1 and all other strobes 0. Sticky until reset.
- Latencies with MEM_HS=0:
  - BRANCH: 3 cycles
  - store: 4 cycles
  - R-type, I-type and upper-immediate: 4 cycles
  - JAL: 4 cycles
  - JALR and load: 5 cycles
  - Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Illegal or unused state encodings recover to FETCH.

Decomposition:
- Package rv32_ctrl_pkg holds the opcode localparams, the state enum, and the select encodings for result_src, alu_src_a, alu_src_b and alu_op.
- One combinational sub-module, rv32_opdec, maps opcode plus the EN_* parameters to a one-hot instruction class and an illegal flag. DECODE's transition logic uses it.

Test Plan:
- Reset: rst_n=0 for 3 cycles with mem_ready=1 -> all strobes 0. After release -> mem_read=1, pc_write=ir_write=1 in the first cycle.
- add (0110011), mem_ready=1 -> states FETCH, DECODE, EXEC_R, ALUWB. reg_write=1 only in cycle 4; alu_op=10 in cycle 3.
- lw (0000011), mem_ready low for 2 cycles in MEMREAD -> MEMREAD held 3 cycles, mem_read and adr_src=1 throughout. MEMWB result_src=01, total 7 cycles.
- sw (0100011) -> mem_write=1 exactly in the handshake cycle(s) and reg_write never asserts. beq (1100011) -> branch=1 for one cycle, alu_op=01.
- jalr (1100111) with EN_JALR=1 -> JALR_ADR, JAL (pc_write=1), ALUWB. With EN_JALR=0 -> TRAP, illegal=1, held until rst_n pulse.
- Opcode 1111111 -> TRAP. rst_n asserted during MEMWRITE -> mem_write drops in the same cycle without waiting for a clock edge.

Source files
------------

// File: rtl/rv32_ctrl_pkg.sv
// rv32_ctrl_pkg
// Shared definitions for the RV32I multi-cycle controller:
//   - opcode constants for every instruction class the controller knows
//   - the controller state enum (4-bit encoding, two codes unused)
//   - select encodings for result_src, alu_src_a, alu_src_b and alu_op
//   - bit positions of the one-hot instruction class vector from rv32_opdec
package rv32_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_JALR_ADR = 4'd9,
    S_JAL      = 4'd10,
    S_BRANCH   = 4'd11,
    S_UPPER    = 4'd12,
    S_TRAP     = 4'd13
  } ctrl_state_e;

  // result mux
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  // ALU A operand
  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLDPC  = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;
  localparam logic [1:0] SRCA_ZERO   = 2'b11;

  // ALU B operand
  localparam logic [1:0] SRCB_RS2    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  // ALU operation class
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  // One-hot instruction class bit positions
  localparam int CLS_W      = 7;
  localparam int CLS_MEM    = 0;
  localparam int CLS_R      = 1;
  localparam int CLS_I      = 2;
  localparam int CLS_JAL    = 3;
  localparam int CLS_JALR   = 4;
  localparam int CLS_BRANCH = 5;
  localparam int CLS_UPPER  = 6;

endpackage

// File: rtl/rv32_opdec.sv
// rv32_opdec
// Combinational opcode classifier used by the DECODE state.
// Ports:
//   opcode  in  7      IR[6:0]
//   cls     out CLS_W  one-hot instruction class (all zero when illegal)
//   illegal out 1      opcode unknown or its class disabled by parameter
module rv32_opdec
  import rv32_ctrl_pkg::*;
#(
  parameter bit EN_JALR  = 1'b1,
  parameter bit EN_UPPER = 1'b1
) (
  input  logic [6:0]       opcode,
  output logic [CLS_W-1:0] cls,
  output logic             illegal
);

  always_comb begin
    cls = '0;
    case (opcode)
      OP_LOAD, OP_STORE: cls[CLS_MEM]    = 1'b1;
      OP_R:              cls[CLS_R]      = 1'b1;
      OP_I:              cls[CLS_I]      = 1'b1;
      OP_JAL:            cls[CLS_JAL]    = 1'b1;
      OP_JALR:           cls[CLS_JALR]   = EN_JALR;
      OP_BRANCH:         cls[CLS_BRANCH] = 1'b1;
      OP_LUI, OP_AUIPC:  cls[CLS_UPPER]  = EN_UPPER;
      default:           cls             = '0;
    endcase
    // A disabled class leaves the vector empty, so it falls out as illegal.
    illegal = ~|cls;
  end

endmodule

// File: rtl/rv32_mc_control.sv
// rv32_mc_control
// Multi-cycle Moore controller for the RV32I shared-ALU / single-memory
// datapath. Sequences FETCH, DECODE, execute, memory and writeback states.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   opcode[6:0]     IR opcode field, stable from DECODE to the next FETCH
//   mem_ready       memory accepted the write / returned read data
//   pc_write        unconditional PC load
//   branch          conditional PC load (qualified by the datapath)
//   adr_src         memory address: 0 = PC, 1 = ALUOut
//   mem_read        memory read request
//   mem_write       memory write request
//   ir_write        IR and OldPC load
//   result_src[1:0] result mux select
//   alu_src_a[1:0]  ALU A select
//   alu_src_b[1:0]  ALU B select
//   alu_op[1:0]     ALU operation class
//   reg_write       register file write
//   illegal         high in TRAP
//   state_dbg[3:0]  current state register, for observation only
//
// Handshake: a memory request (mem_read / mem_write) is held every cycle
// the FSM sits in a memory state; the transfer completes in the cycle
// mem_ready is high, and the FSM leaves that state on the following edge.
// ir_write / pc_write in FETCH are asserted only in that completing cycle.
module rv32_mc_control
  import rv32_ctrl_pkg::*;
#(
  parameter bit EN_JALR  = 1'b1,
  parameter bit EN_UPPER = 1'b1,
  parameter bit MEM_HS   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       branch,
  output logic       adr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  ctrl_state_e      state;
  logic [CLS_W-1:0] cls;
  logic             op_illegal;
  logic             mem_rdy;

  assign mem_rdy   = MEM_HS ? mem_ready : 1'b1;
  assign state_dbg = state;

  rv32_opdec #(
    .EN_JALR  (EN_JALR),
    .EN_UPPER (EN_UPPER)
  ) u_opdec (
    .opcode  (opcode),
    .cls     (cls),
    .illegal (op_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    if (mem_rdy) state <= S_DECODE;
        S_DECODE: begin
          if (op_illegal)            state <= S_TRAP;
          else if (cls[CLS_MEM])     state <= S_MEMADR;
          else if (cls[CLS_R])       state <= S_EXEC_R;
          else if (cls[CLS_I])       state <= S_EXEC_I;
          else if (cls[CLS_JAL])     state <= S_JAL;
          else if (cls[CLS_JALR])    state <= S_JALR_ADR;
          else if (cls[CLS_BRANCH])  state <= S_BRANCH;
          else                       state <= S_UPPER;
        end
        // opcode[5] separates stores (0100011) from loads (0000011)
        S_MEMADR:   state <= opcode[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (mem_rdy) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (mem_rdy) state <= S_FETCH;
        S_EXEC_R:   state <= S_ALUWB;
        S_EXEC_I:   state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_JALR_ADR: state <= S_JAL;
        S_JAL:      state <= S_ALUWB;
        S_BRANCH:   state <= S_FETCH;
        S_UPPER:    state <= S_ALUWB;
        S_TRAP:     state <= S_TRAP;
        default:    state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_rdy;
        pc_write   = mem_rdy;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR, S_JALR_ADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
      end
      S_JAL: begin
        // PC loads the target already in ALUOut while the ALU builds OldPC+4.
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_BRANCH;
        branch    = 1'b1;
      end
      S_UPPER: begin
        // LUI adds imm to zero, AUIPC adds imm to the instruction's PC.
        alu_src_a = opcode[5] ? SRCA_ZERO : SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
      end
    endcase

    // Reset kills every strobe immediately, including FETCH's mem_read,
    // so an abandoned instruction can never complete a write.
    if (!rst_n) begin
      pc_write  = 1'b0;
      branch    = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end

endmodule

// File: tb/tb_rv32_mc_control.sv
// tb_rv32_mc_control
// Directed bench for rv32_mc_control. dut0 uses default parameters; dut1
// has EN_JALR=0, EN_UPPER=0, MEM_HS=0. Control outputs are packed as
//   {pc_write, branch, adr_src, mem_read, mem_write, ir_write,
//    result_src[1:0], alu_src_a[1:0], alu_src_b[1:0], alu_op[1:0],
//    reg_write, illegal}
module tb_rv32_mc_control;
  import rv32_ctrl_pkg::*;

  // Expected control words, hand-derived per state.
  localparam logic [15:0] C_RESET    = 16'b000000_10_00_10_00_00;
  localparam logic [15:0] C_FETCH    = 16'b100101_10_00_10_00_00;
  localparam logic [15:0] C_FETCH_W  = 16'b000100_10_00_10_00_00;
  localparam logic [15:0] C_DECODE   = 16'b000000_00_01_01_00_00;
  localparam logic [15:0] C_MEMADR   = 16'b000000_00_10_01_00_00;
  localparam logic [15:0] C_MEMREAD  = 16'b001100_00_00_00_00_00;
  localparam logic [15:0] C_MEMWB    = 16'b000000_01_00_00_00_10;
  localparam logic [15:0] C_MEMWRITE = 16'b001010_00_00_00_00_00;
  localparam logic [15:0] C_EXEC_R   = 16'b000000_00_10_00_10_00;
  localparam logic [15:0] C_EXEC_I   = 16'b000000_00_10_01_10_00;
  localparam logic [15:0] C_ALUWB    = 16'b000000_00_00_00_00_10;
  localparam logic [15:0] C_JALR_ADR = 16'b000000_00_10_01_00_00;
  localparam logic [15:0] C_JAL      = 16'b100000_00_01_10_00_00;
  localparam logic [15:0] C_BRANCH   = 16'b010000_00_10_00_01_00;
  localparam logic [15:0] C_LUI      = 16'b000000_00_11_01_00_00;
  localparam logic [15:0] C_AUIPC    = 16'b000000_00_01_01_00_00;
  localparam logic [15:0] C_TRAP     = 16'b000000_00_00_00_00_01;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'b0;
  logic       mem_ready = 1'b1;

  logic       pc_write0, branch0, adr_src0, mem_read0, mem_write0, ir_write0, reg_write0, illegal0;
  logic [1:0] result_src0, alu_src_a0, alu_src_b0, alu_op0;
  logic [3:0] state0;
  logic       pc_write1, branch1, adr_src1, mem_read1, mem_write1, ir_write1, reg_write1, illegal1;
  logic [1:0] result_src1, alu_src_a1, alu_src_b1, alu_op1;
  logic [3:0] state1;
  logic [15:0] ctl0, ctl1;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rv32_mc_control dut0 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write0), .branch(branch0), .adr_src(adr_src0),
    .mem_read(mem_read0), .mem_write(mem_write0), .ir_write(ir_write0),
    .result_src(result_src0), .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0),
    .alu_op(alu_op0), .reg_write(reg_write0), .illegal(illegal0),
    .state_dbg(state0)
  );

  rv32_mc_control #(.EN_JALR(1'b0), .EN_UPPER(1'b0), .MEM_HS(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write1), .branch(branch1), .adr_src(adr_src1),
    .mem_read(mem_read1), .mem_write(mem_write1), .ir_write(ir_write1),
    .result_src(result_src1), .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1),
    .alu_op(alu_op1), .reg_write(reg_write1), .illegal(illegal1),
    .state_dbg(state1)
  );

  assign ctl0 = {pc_write0, branch0, adr_src0, mem_read0, mem_write0, ir_write0,
                 result_src0, alu_src_a0, alu_src_b0, alu_op0, reg_write0, illegal0};
  assign ctl1 = {pc_write1, branch1, adr_src1, mem_read1, mem_write1, ir_write1,
                 result_src1, alu_src_a1, alu_src_b1, alu_op1, reg_write1, illegal1};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: apply mem_ready, settle, check one DUT's state
  // and control word, then advance to the next falling edge.
  task automatic cyc(input string tag, input int which, input logic mr,
                     input ctrl_state_e es, input logic [15:0] ec);
    mem_ready = mr;
    #1;
    if (which == 0) begin
      check_eq({tag, "_st"}, {28'd0, state0}, {28'd0, es});
      check_eq({tag, "_ctl"}, {16'd0, ctl0}, {16'd0, ec});
    end else begin
      check_eq({tag, "_st"}, {28'd0, state1}, {28'd0, es});
      check_eq({tag, "_ctl"}, {16'd0, ctl1}, {16'd0, ec});
    end
    @(negedge clk);
  endtask

  // Hold reset for n cycles, checking dut0's reset outputs, then release on
  // a falling edge so the first FETCH is the very next check.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      check_eq("rst_ctl", {16'd0, ctl0}, {16'd0, C_RESET});
      check_eq("rst_ctl1", {16'd0, ctl1}, {16'd0, C_RESET});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset(3);

    // add
    opcode = OP_R;
    cyc("add_f", 0, 1'b1, S_FETCH, C_FETCH);
    cyc("add_d", 0, 1'b1, S_DECODE, C_DECODE);
    cyc("add_x", 0, 1'b1, S_EXEC_R, C_EXEC_R);
    cyc("add_wb", 0, 1'b1, S_ALUWB, C_ALUWB);

    // lw with two wait cycles in MEMREAD
    opcode = OP_LOAD;
    cyc("lw_f", 0, 1'b1, S_FETCH, C_FETCH);
    cyc("lw_d", 0, 1'b1, S_DECODE, C_DECODE);
    cyc("lw_a", 0, 1'b1, S_MEMADR, C_MEMADR);
    cyc("lw_r0", 0, 1'b0, S_MEMREAD, C_MEMREAD);
    cyc("lw_r1", 0, 1'b0, S_MEMREAD, C_MEMREAD);
    cyc("lw_r2", 0, 1'b1, S_MEMREAD, C_MEMREAD);
    cyc("lw_wb", 0, 1'b1, S_MEMWB, C_MEMWB);

    // sw with one wait cycle, fetch stalled one cycle first
    opcode = OP_STORE;
    cyc("sw_fw", 0, 1'b0, S_FETCH, C_FETCH_W);
    cyc("sw_f", 0, 1'b1, S_FETCH, C_FETCH);
    cyc("sw_d", 0, 1'b1, S_DECODE, C_DECODE);
    cyc("sw_a", 0, 1'b1, S_MEMADR, C_MEMADR);
    cyc("sw_w0", 0, 1'b0, S_MEMWRITE, C_MEMWRITE);
    cyc("sw_w1", 0, 1'b1, S_MEMWRITE, C_MEMWRITE);

    // beq
    opcode = OP_BRANCH;
    cyc("beq_f", 0, 1'b1, S_FETCH, C_FETCH);
    cyc("beq_d", 0, 1'b1, S_DECODE, C_DECODE);
    cyc("beq_b", 0, 1'b1, S_BRANCH, C_BRANCH);

    // jalr
    opcode = OP_JALR;
    cyc("jalr_f", 0, 1'b1, S_FETCH, C_FETCH);
    cyc("jalr_d", 0, 1'b1, S_DECODE, C_DECODE);
    cyc("jalr_a", 0, 1'b1, S_JALR_ADR, C_JALR_ADR);
    cyc("jalr_j", 0, 1'b1, S_JAL, C_JAL);
    cyc("jalr_wb", 0, 1'b1, S_ALUWB, C_ALUWB);

    // jal
    opcode = OP_JAL;
    cyc("jal_f", 0, 1'b1, S_FETCH, C_FETCH);
    cyc("jal_d", 0, 1'b1, S_DECODE, C_DECODE);
    cyc("jal_j", 0, 1'b1, S_JAL, C_JAL);
    cyc("jal_wb", 0, 1'b1, S_ALUWB, C_ALUWB);

    // addi
    opcode = OP_I;
    cyc("addi_f", 0, 1'b1, S_FETCH, C_FETCH);
    cyc("addi_d", 0, 1'b1, S_DECODE, C_DECODE);
    cyc("addi_x", 0, 1'b1, S_EXEC_I, C_EXEC_I);
    cyc("addi_wb", 0, 1'b1, S_ALUWB, C_ALUWB);

    // lui, auipc
    opcode = OP_LUI;
    cyc("lui_f", 0, 1'b1, S_FETCH, C_FETCH);
    cyc("lui_d", 0, 1'b1, S_DECODE, C_DECODE);
    cyc("lui_u", 0, 1'b1, S_UPPER, C_LUI);
    cyc("lui_wb", 0, 1'b1, S_ALUWB, C_ALUWB);
    opcode = OP_AUIPC;
    cyc("auipc_f", 0, 1'b1, S_FETCH, C_FETCH);
    cyc("auipc_d", 0, 1'b1, S_DECODE, C_DECODE);
    cyc("auipc_u", 0, 1'b1, S_UPPER, C_AUIPC);
    cyc("auipc_wb", 0, 1'b1, S_ALUWB, C_ALUWB);

    // illegal opcode: TRAP is sticky even when a legal opcode follows
    opcode = 7'b1111111;
    cyc("ill_f", 0, 1'b1, S_FETCH, C_FETCH);
    cyc("ill_d", 0, 1'b1, S_DECODE, C_DECODE);
    cyc("ill_t0", 0, 1'b1, S_TRAP, C_TRAP);
    opcode = OP_R;
    cyc("ill_t1", 0, 1'b1, S_TRAP, C_TRAP);
    cyc("ill_t2", 0, 1'b0, S_TRAP, C_TRAP);

    // reset recovers from TRAP; then reset asserted mid-MEMWRITE
    do_reset(2);
    opcode = OP_STORE;
    cyc("rsw_f", 0, 1'b1, S_FETCH, C_FETCH);
    cyc("rsw_d", 0, 1'b1, S_DECODE, C_DECODE);
    cyc("rsw_a", 0, 1'b1, S_MEMADR, C_MEMADR);
    mem_ready = 1'b0;
    #1;
    check_eq("rsw_mw_pre", {31'd0, mem_write0}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rsw_mw_async", {31'd0, mem_write0}, 32'd0);
    check_eq("rsw_st_async", {28'd0, state0}, {28'd0, S_FETCH});
    check_eq("rsw_ctl_async", {16'd0, ctl0}, {16'd0, C_RESET});

    // dut1: JALR disabled, MEM_HS=0 so mem_ready=0 never stalls it
    do_reset(1);
    opcode = OP_JALR;
    cyc("nj_f", 1, 1'b0, S_FETCH, C_FETCH);
    cyc("nj_d", 1, 1'b0, S_DECODE, C_DECODE);
    cyc("nj_t0", 1, 1'b0, S_TRAP, C_TRAP);
    cyc("nj_t1", 1, 1'b1, S_TRAP, C_TRAP);
    do_reset(1);
    opcode = OP_LUI;
    cyc("nu_f", 1, 1'b1, S_FETCH, C_FETCH);
    cyc("nu_d", 1, 1'b1, S_DECODE, C_DECODE);
    cyc("nu_t", 1, 1'b1, S_TRAP, C_TRAP);
    do_reset(1);
    opcode = OP_LOAD;
    cyc("nhs_f", 1, 1'b0, S_FETCH, C_FETCH);
    cyc("nhs_d", 1, 1'b0, S_DECODE, C_DECODE);
    cyc("nhs_a", 1, 1'b0, S_MEMADR, C_MEMADR);
    cyc("nhs_r", 1, 1'b0, S_MEMREAD, C_MEMREAD);
    cyc("nhs_wb", 1, 1'b0, S_MEMWB, C_MEMWB);
    cyc("nhs_f2", 1, 1'b0, S_FETCH, C_FETCH);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
